// File: rtl/types.sv
// Shared type package.
//   u32_t    : 32-bit machine word used for addresses and instruction words.
//   IA_RESET : default instruction address fetched first after reset.
package types;

    typedef logic [31:0] u32_t;

    localparam u32_t IA_RESET = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_buffer.sv
// Ring buffer between instruction memory and the IF/ID boundary.
// A slot is allocated (tagged with its ia+4) when a fetch is accepted, filled
// when the matching response returns, and freed when ID dequeues it.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   alloc             : fetch accepted; claim slot at alloc_ptr
//   alloc_ia_plus_4   : ia+4 of the accepted fetch
//   fill, fill_ir     : response for the oldest unfilled slot
//   deq               : ID consumes the head slot
//   flush             : redirect; empty the ring and rebase pointers on head
//   head_valid        : head slot is filled
//   head_ir           : head instruction, 0 when not valid
//   head_ia_plus_4    : head ia+4, 0 when not valid
//   filled_cnt        : number of filled slots
module if_fetch_buffer
    import types::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc,
    input  u32_t          alloc_ia_plus_4,
    input  logic          fill,
    input  u32_t          fill_ir,
    input  logic          deq,
    input  logic          flush,
    output logic          head_valid,
    output u32_t          head_ir,
    output u32_t          head_ia_plus_4,
    output logic [CW-1:0] filled_cnt
);

    u32_t             ir_q     [DEPTH];
    u32_t             ir_d     [DEPTH];
    u32_t             iap4_q   [DEPTH];
    u32_t             iap4_d   [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]    head_ptr_q, head_ptr_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        ir_d        = ir_q;
        iap4_d      = iap4_q;
        filled_d    = filled_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        if (flush) begin
            filled_d    = '0;
            alloc_ptr_d = head_ptr_q;
            fill_ptr_d  = head_ptr_q;
        end else begin
            if (deq) begin
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d           = head_ptr_q + PW'(1);
            end
            // With a full ring, alloc may target the slot being dequeued;
            // both paths clear filled, so the order here is harmless.
            if (alloc) begin
                iap4_d[alloc_ptr_q]   = alloc_ia_plus_4;
                filled_d[alloc_ptr_q] = 1'b0;
                alloc_ptr_d           = alloc_ptr_q + PW'(1);
            end
            if (fill) begin
                ir_d[fill_ptr_q]     = fill_ir;
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ir_q[i]   <= '0;
                iap4_q[i] <= '0;
            end
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
        end else begin
            ir_q        <= ir_d;
            iap4_q      <= iap4_d;
            filled_q    <= filled_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
        end
    end

    always_comb begin
        filled_cnt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            filled_cnt = filled_cnt + CW'(filled_q[i]);
        end
    end

    assign head_valid     = filled_q[head_ptr_q];
    assign head_ir        = head_valid ? ir_q[head_ptr_q]   : '0;
    assign head_ia_plus_4 = head_valid ? iap4_q[head_ptr_q] : '0;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage. Issues word fetches, buffers returned instructions
// and presents them in order to the decode stage. Branch redirects flush the
// buffer; responses to fetches still in flight at a redirect are dropped.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem_req     : fetch request valid (independent of imem_ready)
//   imem_addr    : word-aligned fetch address, held until accepted
//   imem_ready   : memory accepts the request this cycle
//   imem_rvalid  : in-order response valid
//   imem_rdata   : instruction word
//   redirect     : EX branch taken; flush and refetch from redirect_ia
//   redirect_ia  : new fetch address, bits [1:0] ignored
//   stall        : ID holds the head instruction
//   ir           : head instruction (0 when not valid)
//   ia_plus_4    : head instruction address + 4 (0 when not valid)
//   valid        : head instruction present
module if_stage
    import types::*;
#(
    parameter u32_t        RESET_IA = IA_RESET,
    parameter int unsigned DEPTH    = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic imem_req,
    output u32_t imem_addr,
    input  logic imem_ready,
    input  logic imem_rvalid,
    input  u32_t imem_rdata,
    input  logic redirect,
    input  u32_t redirect_ia,
    input  logic stall,
    output u32_t ir,
    output u32_t ia_plus_4,
    output logic valid
);

    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    u32_t          ia_q, ia_d;
    logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0] discard_cnt_q, discard_cnt_d;
    logic [CW-1:0] filled_cnt;
    logic [CW-1:0] live_cnt;
    logic [CW-1:0] in_flight;
    logic          deq;
    logic          accept;
    logic          drop;
    logic          fill;
    u32_t          redirect_ia_w;
    u32_t          ia_next;

    assign redirect_ia_w = redirect_ia & 32'hFFFF_FFFC;
    assign ia_next       = ia_q + 32'd4;

    assign deq      = valid && !stall && !redirect;
    assign live_cnt = alloc_cnt_q - discard_cnt_q;

    // A dequeue this cycle frees a slot, so a full ring may still issue.
    // Gated by rst_n so the request drops as soon as reset asserts.
    assign imem_req  = rst_n && !redirect
                     && ((live_cnt < DEPTH_C) || deq)
                     && ((alloc_cnt_q < DEPTH_C) || deq);
    assign imem_addr = ia_q;
    assign accept    = imem_req && imem_ready;

    assign drop = imem_rvalid && !redirect && (discard_cnt_q != '0);
    assign fill = imem_rvalid && !redirect && (discard_cnt_q == '0);

    // alloc_cnt counts discard credits too, so this includes stale fetches.
    assign in_flight = alloc_cnt_q - filled_cnt;

    always_comb begin
        ia_d          = ia_q;
        alloc_cnt_d   = alloc_cnt_q;
        discard_cnt_d = discard_cnt_q;
        if (redirect) begin
            ia_d = redirect_ia_w;
            // Any response arriving during the redirect is lost with the flush.
            if (imem_rvalid && (in_flight != '0)) begin
                discard_cnt_d = in_flight - CW'(1);
            end else begin
                discard_cnt_d = in_flight;
            end
            // Outstanding stale responses keep their credit until they return.
            alloc_cnt_d = discard_cnt_d;
        end else begin
            if (accept) begin
                ia_d = ia_next;
            end
            if (drop) begin
                discard_cnt_d = discard_cnt_q - CW'(1);
            end
            alloc_cnt_d = alloc_cnt_q + CW'(accept) - CW'(deq) - CW'(drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ia_q          <= RESET_IA;
            alloc_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            ia_q          <= ia_d;
            alloc_cnt_q   <= alloc_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    if_fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc           (accept),
        .alloc_ia_plus_4 (ia_next),
        .fill            (fill),
        .fill_ir         (imem_rdata),
        .deq             (deq),
        .flush           (redirect),
        .head_valid      (valid),
        .head_ir         (ir),
        .head_ia_plus_4  (ia_plus_4),
        .filled_cnt      (filled_cnt)
    );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: memory model with configurable latency, expected
// instruction stream queued by the stimulus and popped by a monitor on every
// dequeue, plus directed checks on timing, stall, redirect, backpressure,
// address wrap and mid-run reset.
module tb_if_stage;
    import types::*;

    localparam u32_t RIA = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n;
    logic imem_req;
    u32_t imem_addr;
    logic imem_ready;
    logic imem_rvalid;
    u32_t imem_rdata;
    logic redirect;
    u32_t redirect_ia;
    logic stall;
    u32_t ir;
    u32_t ia_plus_4;
    logic valid;

    if_stage #(
        .RESET_IA (RIA),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_ia (redirect_ia),
        .stall       (stall),
        .ir          (ir),
        .ia_plus_4   (ia_plus_4),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        u32_t ir;
        u32_t iap4;
    } exp_t;

    typedef struct packed {
        u32_t        addr;
        int unsigned due;
    } req_t;

    exp_t        exp_q[$];
    req_t        pend[$];
    u32_t        acc_log[$];
    exp_t        mon_e;
    int unsigned cyc   = 0;
    int unsigned lat   = 1;
    int unsigned n_deq = 0;
    int unsigned n_acc = 0;
    int          tests = 0;
    int          fails = 0;

    // Instruction memory contents: each word is the bitwise inverse of its address.
    function automatic u32_t memf(input u32_t a);
        return ~a;
    endfunction

    function automatic void push_stream(input u32_t start);
        u32_t a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back('{ir: memf(a), iap4: a + 32'd4});
            a = a + 32'd4;
        end
    endfunction

    task automatic chk(input string nm, input u32_t act, input u32_t expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        #1;
        while (!valid && n < 30) begin
            tick();
            #1;
            n++;
        end
        tests++;
        if (!valid) begin
            fails++;
            $display("FAIL %s: valid still 0 after %0d cycles, expected 1", nm, n);
        end
    endtask

    // Memory: record accepted requests, return responses in order after lat cycles.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ready) begin
            pend.push_back('{addr: imem_addr, due: cyc + lat});
            acc_log.push_back(imem_addr);
            n_acc++;
        end
    end

    always @(negedge rst_n) pend.delete();

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    // Monitor: every dequeue must match the next expected instruction.
    always @(negedge clk) begin
        if (rst_n && valid && !stall && !redirect) begin
            n_deq++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got ir 0x%08h, expected no instruction", ir);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_ir", ir, mon_e.ir);
                chk("sb_ia_plus_4", ia_plus_4, mon_e.iap4);
            end
        end
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        u32_t        hold_ir;
        u32_t        hold_iap4;
        u32_t        rec;
        int unsigned acc0;
        int unsigned deq0;
        bit          seen;

        rst_n       = 1'b0;
        imem_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_ia = '0;
        stall       = 1'b0;

        // Reset state
        repeat (2) tick();
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RIA);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ia_plus_4", ia_plus_4, 32'd0);

        // Reset start: first fetch in cycle 0, first valid in cycle 2
        push_stream(RIA);
        tick();
        rst_n = 1'b1;
        #1;
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0000_0100);
        chk("c0_valid", 32'(valid), 32'd0);
        tick();
        #1;
        chk("c1_addr", imem_addr, 32'h0000_0104);
        chk("c1_valid", 32'(valid), 32'd0);
        tick();
        #1;
        chk("c2_valid", 32'(valid), 32'd1);
        chk("c2_ir", ir, 32'hFFFF_FEFF);
        chk("c2_ia_plus_4", ia_plus_4, 32'h0000_0104);
        chk("c2_addr", imem_addr, 32'h0000_0108);
        deq0 = n_deq;
        repeat (8) tick();
        chk("throughput_8cyc", n_deq - deq0, 32'd8);

        // Long stall: outputs frozen, no requests while full
        stall = 1'b1;
        #1;
        hold_ir   = ir;
        hold_iap4 = ia_plus_4;
        acc0      = n_acc;
        chk("stall_valid", 32'(valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("stall_ir", ir, hold_ir);
            chk("stall_ia_plus_4", ia_plus_4, hold_iap4);
            chk("stall_req", 32'(imem_req), 32'd0);
            tick();
            #1;
        end
        chk("stall_no_accept", n_acc - acc0, 32'd0);
        stall = 1'b0;
        repeat (4) tick();

        // Quiesce with a full buffer, then redirect while stalled
        stall = 1'b1;
        repeat (3) tick();
        redirect    = 1'b1;
        redirect_ia = 32'h0000_1000;
        lat         = 3;
        push_stream(32'h0000_1000);
        #1;
        chk("rd0_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        #1;
        chk("rd1_valid", 32'(valid), 32'd0);
        chk("rd1_req", 32'(imem_req), 32'd1);
        chk("rd1_addr", imem_addr, 32'h0000_1000);
        tick();
        #1;
        chk("rd2_req", 32'(imem_req), 32'd1);
        chk("rd2_addr", imem_addr, 32'h0000_1004);
        tick();
        #1;
        chk("rd3_req_full", 32'(imem_req), 32'd0);
        // Two fetches in flight: redirect again, both responses must be dropped
        redirect    = 1'b1;
        redirect_ia = 32'h0000_2000;
        push_stream(32'h0000_2000);
        tick();
        redirect = 1'b0;
        wait_valid("rd_wait_valid");
        chk("rd_ir", ir, 32'hFFFF_DFFF);
        chk("rd_ia_plus_4", ia_plus_4, 32'h0000_2004);

        // Memory backpressure: address held, no acceptance
        lat = 1;
        repeat (6) tick();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            #1;
            seen = imem_req;
        end
        chk("bp_find_req", 32'(seen), 32'd1);
        imem_ready = 1'b0;
        rec        = imem_addr;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req", 32'(imem_req), 32'd1);
            chk("bp_addr", imem_addr, rec);
            tick();
            #1;
        end
        imem_ready = 1'b1;
        acc0       = n_acc;
        tick();
        #1;
        chk("bp_one_accept", n_acc - acc0, 32'd1);
        chk("bp_accept_addr", acc_log[$], rec);

        // Address wrap
        redirect    = 1'b1;
        redirect_ia = 32'hFFFF_FFFE;
        push_stream(32'hFFFF_FFFC);
        tick();
        redirect = 1'b0;
        #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 10 && imem_addr == 32'hFFFF_FFFC; i++) begin
            tick();
            #1;
        end
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        wait_valid("wrap_wait_valid");
        chk("wrap_ir", ir, 32'h0000_0003);
        chk("wrap_ia_plus_4", ia_plus_4, 32'h0000_0000);

        // Reset mid-run with a full buffer
        repeat (4) tick();
        stall = 1'b1;
        repeat (3) tick();
        #1;
        chk("pre_rst_valid", 32'(valid), 32'd1);
        rst_n = 1'b0;
        stall = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_ir", ir, 32'd0);
        chk("mid_rst_ia_plus_4", ia_plus_4, 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", imem_addr, RIA);
        push_stream(RIA);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, RIA);
        deq0 = n_deq;
        repeat (12) tick();
        chk("post_rst_deq", n_deq - deq0, 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction Fetch stage. Issues word fetches to instruction memory and buffers the returned instructions in a small ring buffer. It presents them in order to the IF/ID boundary as `ir`, `ia_plus_4` and `valid`, which the Instruction Decode stage consumes. It also accepts branch redirects from EX and stalls from the hazard unit.

## Interface
- `RESET_IA`, default 32'h0000_0000: instruction address fetched first after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: buffer slots, which is also the maximum number of fetches allocated (in flight plus buffered). Power of two, at least 2.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word address of the request; bits [1:0] are always 0.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response valid. Responses return in order, at least 1 cycle after acceptance.
- `imem_rdata` in 32: instruction word.
- `redirect` in 1: EX branch taken; flush and refetch.
- `redirect_ia` in 32: new instruction address; bits [1:0] are ignored and treated as 0.
- `stall` in 1: ID holds; do not advance the head.
- `ir` out 32: head instruction; `'0` when `valid`=0.
- `ia_plus_4` out 32: head instruction address + 4, modulo 2^32; `'0` when `valid`=0.
- `valid` out 1: head slot is filled.

## Operation
- Registers:
  - `ia`: next fetch address.
  - Ring of `DEPTH` slots, each holding {`ia_plus_4`, `ir`, `filled`}.
  - Pointers `alloc_ptr`, `fill_ptr`, `head_ptr`, all wrapping modulo `DEPTH`.
  - `alloc_cnt` (0..`DEPTH`).
  - `discard_cnt` (0..`DEPTH`).
- Reset values: `ia`=`RESET_IA`; all pointers, counts and slots 0; outputs `imem_req`=0, `imem_addr`=`RESET_IA`, `valid`=0, `ir`=0, `ia_plus_4`=0.
- Dequeue: `deq` = `valid` && !`stall` && !`redirect`. It frees the head slot and advances `head_ptr`.
- Issue: `imem_req` = !`redirect` && (`alloc_cnt` − `discard_cnt` < `DEPTH` || `deq`) && (`alloc_cnt` < `DEPTH` || `deq`).
  - `imem_req` never depends on `imem_ready`.
  - `imem_addr` = `ia`.
- Acceptance (`imem_req` && `imem_ready`):
  - Write `ia`+4 into the slot at `alloc_ptr` and set `filled`=0.
  - Advance `alloc_ptr`, increment `alloc_cnt`, and set `ia` <= `ia`+4.
- Request hold: while `imem_req`=1 and `imem_ready`=0, `imem_addr` is held stable. It changes only on acceptance or redirect.
- Response (`imem_rvalid`):
  - If `discard_cnt` > 0: drop the data and decrement `discard_cnt`.
  - Otherwise: write `imem_rdata` into the slot at `fill_ptr`, set `filled`=1, and advance `fill_ptr`.
- Redirect (highest priority):
  - Set `ia` <= {`redirect_ia`[31:2], 2'b00}.
  - Clear all `filled` bits, set every pointer to `head_ptr`, and deassert `imem_req` this cycle.
  - Set `discard_cnt` <= (number of in-flight fetches) − (1 if `imem_rvalid` is dropped this cycle). In-flight fetches = `alloc_cnt` minus filled slots.
  - Set `alloc_cnt` <= new `discard_cnt`, so the dropped responses still hold credit.
- `alloc_cnt` decrements on `deq` and on each discarded response, increments on acceptance, and may do both in the same cycle.
- `alloc_cnt` never exceeds `DEPTH`, so the buffer cannot overflow.
- Redirect and `stall` in the same cycle: redirect wins, and `valid`=0 on the next cycle.
- Address wrap: `ia`=32'hFFFF_FFFC gives `ia_plus_4`=0 and a next fetch address of 0.

## Timing
- Response to `valid`: 1 cycle. Data with `imem_rvalid` high in cycle N appears on `ir` in cycle N+1.
- With 1-cycle memory and `imem_ready`=1, the first request after reset deassertion is accepted in cycle 0. `valid`=1 with the first instruction in cycle 2.
- Steady-state throughput is 1 instruction/cycle with `DEPTH`=2 and 1-cycle memory. `imem_req` has a combinational path from `stall`.
- Redirect in cycle N: `valid`=0 in cycle N+1, and the first request to the new address is in cycle N+1.
- `stall` held: `ir`, `ia_plus_4` and `valid` are stable every cycle.
- Reset asserted mid-operation clears everything asynchronously. Responses arriving after reset deassertion for fetches issued before reset are the memory's responsibility, because memory is reset by the same `rst_n`.

## Structure
- Shared package `types`: `u32_t` (existing). Add the constant `IA_RESET` as the source of the `RESET_IA` default.
- One sub-module, `if_fetch_buffer`, holding the ring slots, pointers and the `filled` bits. It has ports alloc/fill/deq/flush. `if_stage` keeps `ia`, the issue logic and `discard_cnt`.

## Test plan
- **Reset start:** reset with `RESET_IA`=0x100, 1-cycle memory, `imem_ready`=1, `stall`=0 → `imem_addr` sequence 0x100, 0x104, 0x108…; `valid` rises in cycle 2 with `ir`=mem[0x100], `ia_plus_4`=0x104; one instruction per cycle after that.
- **Long stall:** `stall`=1 for 6 cycles → outputs frozen, at most 2 accepted requests outstanding plus buffered, `imem_req`=0 while full. Releasing the stall resumes in order with no loss or duplication.
- **Redirect with fetches in flight:** 3-cycle memory latency with 2 fetches in flight, redirect to 0x2000 → both stale responses dropped, next `valid` shows `ir`=mem[0x2000] and `ia_plus_4`=0x2004.
- **Memory backpressure:** `imem_ready`=0 for 3 cycles with `imem_req`=1 → `imem_addr` held at the same value, no slot allocated.
- **Address wrap:** redirect to 0xFFFF_FFFE → `imem_addr`=0xFFFF_FFFC, head `ia_plus_4`=0, next `imem_addr`=0.
- **Reset mid-run:** assert `rst_n`=0 mid-run with a full buffer → `valid`, `ir`, `ia_plus_4` and `imem_req` go to 0 immediately, and fetching restarts at `RESET_IA`.
